// File: rtl/float_pkg.sv
// Half-precision float constants, special encodings and FSM states
// shared by the vector FPU lane datapaths (MAC, divider).
package float_pkg;
  localparam int E_WIDTH = 5;
  localparam int M_WIDTH = 10;
  localparam int I_WIDTH = M_WIDTH + E_WIDTH + 1;
  localparam int BIAS    = (1 << (E_WIDTH - 1)) - 1;
  localparam int Q_WIDTH = M_WIDTH + 3;
  localparam int R_WIDTH = M_WIDTH + 2;
  localparam int X_WIDTH = E_WIDTH + 2;
  localparam int C_WIDTH = $clog2(Q_WIDTH);

  localparam logic [I_WIDTH-1:0] NAN =
    {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};
  localparam logic [I_WIDTH-1:0] P_INFI =
    {1'b0, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
  localparam logic [I_WIDTH-1:0] N_INFI =
    {1'b1, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
  localparam logic [I_WIDTH-1:0] P_ZERO = '0;
  localparam logic [I_WIDTH-1:0] N_ZERO =
    {1'b1, {(I_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_t;

  function automatic logic [I_WIDTH-1:0] inf_of(input logic s);
    return s ? N_INFI : P_INFI;
  endfunction

  function automatic logic [I_WIDTH-1:0] zero_of(input logic s);
    return s ? N_ZERO : P_ZERO;
  endfunction
endpackage

// File: rtl/float_special_detect.sv
// Operand classifier for divide: flags special cases and gives
// their fixed result and divide-by-zero flag. Subnormals read as zero.
module float_special_detect
  import float_pkg::*;
(
  input  logic [I_WIDTH-1:0] a,
  input  logic [I_WIDTH-1:0] b,
  output logic               special,
  output logic [I_WIDTH-1:0] res,
  output logic               dz
);
  logic s;
  logic a_emax, a_mz, a_nan, a_inf, a_zero;
  logic b_emax, b_mz, b_nan, b_inf, b_zero;

  assign s      = a[I_WIDTH-1] ^ b[I_WIDTH-1];
  assign a_emax = &a[I_WIDTH-2:M_WIDTH];
  assign a_mz   = ~|a[M_WIDTH-1:0];
  assign a_nan  = a_emax & ~a_mz;
  assign a_inf  = a_emax & a_mz;
  assign a_zero = ~|a[I_WIDTH-2:M_WIDTH];
  assign b_emax = &b[I_WIDTH-2:M_WIDTH];
  assign b_mz   = ~|b[M_WIDTH-1:0];
  assign b_nan  = b_emax & ~b_mz;
  assign b_inf  = b_emax & b_mz;
  assign b_zero = ~|b[I_WIDTH-2:M_WIDTH];

  always_comb begin
    special = 1'b1;
    res     = NAN;
    dz      = 1'b0;
    if (a_nan | b_nan) begin
      res = NAN;
    end else if (a_inf & b_inf) begin
      res = NAN;
    end else if (a_zero & b_zero) begin
      res = NAN;
    end else if (a_inf) begin
      res = inf_of(s);
    end else if (b_inf) begin
      res = zero_of(s);
    end else if (b_zero) begin
      res = inf_of(s);
      dz  = 1'b1;
    end else if (a_zero) begin
      res = zero_of(s);
    end else begin
      special = 1'b0;
      res     = P_ZERO;
    end
  end
endmodule

// File: rtl/float_div_iter.sv
// Sequential float divider: radix-2 restoring, one quotient bit
// per clock, then a round-to-nearest-even pack stage.
module float_div_iter
  import float_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] a,
  input  logic [I_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] q,
  output logic               dz
);
  state_t state, state_nxt;
  logic [C_WIDTH-1:0] cnt;
  logic [R_WIDTH-1:0] rem, div, rem_sub;
  logic [Q_WIDTH-1:0] quot, norm;
  logic [X_WIDTH-1:0] exp, exp_n, exp_r;
  logic [M_WIDTH:0]   kept;
  logic [M_WIDTH+1:0] sum;
  logic sign, accept, ge, last;
  logic guard, sticky, up;
  logic sp_flag, sp_dz;
  logic [I_WIDTH-1:0] sp_res, rnd_res;

  float_special_detect u_special (
    .a      (a),
    .b      (b),
    .special(sp_flag),
    .res    (sp_res),
    .dz     (sp_dz)
  );

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign last      = cnt == C_WIDTH'(Q_WIDTH - 1);
  assign ge        = rem >= div;
  assign rem_sub   = ge ? rem - div : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = sp_flag ? DONE : CALC;
      CALC:    if (last) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Quotient below 1.0 gets one extra shift; guard/sticky cover the rest.
  always_comb begin
    norm   = quot[Q_WIDTH-1] ? quot : quot << 1;
    exp_n  = quot[Q_WIDTH-1] ? exp : exp - X_WIDTH'(1);
    kept   = norm[Q_WIDTH-1:2];
    guard  = norm[1];
    sticky = norm[0] | (|rem);
    up     = guard & (sticky | kept[0]);
    sum    = {1'b0, kept} + {{(M_WIDTH+1){1'b0}}, up};
    exp_r  = sum[M_WIDTH+1] ? exp_n + X_WIDTH'(1) : exp_n;
    if ($signed(exp_r) >= $signed(X_WIDTH'((1 << E_WIDTH) - 1)))
      rnd_res = inf_of(sign);
    else if ($signed(exp_r) < $signed(X_WIDTH'(1)))
      rnd_res = zero_of(sign);
    else
      rnd_res = {sign, exp_r[E_WIDTH-1:0], sum[M_WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rem  <= '0;
      div  <= '0;
      quot <= '0;
      exp  <= '0;
      sign <= 1'b0;
      q    <= '0;
      dz   <= 1'b0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        rem  <= {1'b0, 1'b1, a[M_WIDTH-1:0]};
        div  <= {1'b0, 1'b1, b[M_WIDTH-1:0]};
        quot <= '0;
        exp  <= {2'b00, a[I_WIDTH-2:M_WIDTH]}
              - {2'b00, b[I_WIDTH-2:M_WIDTH]}
              + X_WIDTH'(BIAS);
        sign <= a[I_WIDTH-1] ^ b[I_WIDTH-1];
        if (sp_flag) begin
          q  <= sp_res;
          dz <= sp_dz;
        end
      end
      if (state == CALC) begin
        cnt  <= cnt + C_WIDTH'(1);
        rem  <= {rem_sub[R_WIDTH-2:0], 1'b0};
        quot <= {quot[Q_WIDTH-2:0], ge};
      end
      if (state == ROUND) begin
        q  <= rnd_res;
        dz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_float_div_iter.sv
// Bench for float_div_iter: directed vectors, random operands
// against an exact-rational division model, back-pressure and reset.
module tb_float_div_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] q;
  logic        dz;
  int checks = 0;
  int errors = 0;

  float_div_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Exact quotient of the significands, rounded to nearest-even.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic rdz);
    logic s, xn, xi, xz, yn, yi, yz;
    int ex, ey, e;
    longint mx, my, num, qi, rm;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    xn = (ex == 31) && (x[9:0] != 0);
    xi = (ex == 31) && (x[9:0] == 0);
    xz = ex == 0;
    yn = (ey == 31) && (y[9:0] != 0);
    yi = (ey == 31) && (y[9:0] == 0);
    yz = ey == 0;
    rdz = 1'b0;
    if (xn || yn) r = 16'h7E00;
    else if (xi && yi) r = 16'h7E00;
    else if (xz && yz) r = 16'h7E00;
    else if (xi) r = {s, 15'h7C00};
    else if (yi) r = {s, 15'h0000};
    else if (yz) begin
      r = {s, 15'h7C00};
      rdz = 1'b1;
    end else if (xz) r = {s, 15'h0000};
    else begin
      mx = 1024 + longint'(x[9:0]);
      my = 1024 + longint'(y[9:0]);
      e  = ex - ey + 15;
      if (mx >= my) num = mx * 1024;
      else begin
        num = mx * 2048;
        e = e - 1;
      end
      qi = num / my;
      rm = num % my;
      if (2 * rm > my || (2 * rm == my && qi % 2 == 1)) qi = qi + 1;
      if (qi == 2048) begin
        qi = 1024;
        e = e + 1;
      end
      if (e >= 31) r = {s, 15'h7C00};
      else if (e < 1) r = {s, 15'h0000};
      else r = {s, 5'(e), 10'(qi - 1024)};
    end
  endfunction

  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] rq, output logic rdz,
                       output int lat, output logic rdy_seen);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    rq = q;
    rdz = dz;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (q !== 16'h0000 || dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_q_dz: got %h/%b expected 0000/0", q, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [16] = '{16'h4600, 16'h3C00, 16'hC000, 16'h7BFF,
                             16'h0400, 16'h3C00, 16'h0000, 16'h7C00,
                             16'h7E01, 16'hFC00, 16'h3C00, 16'h8000,
                             16'h3C00, 16'h0001, 16'h7C00, 16'h3C00};
    logic [15:0] vb [16] = '{16'h4000, 16'h4200, 16'h3800, 16'h3800,
                             16'h7800, 16'h0000, 16'h0000, 16'h7C00,
                             16'h3C00, 16'h3C00, 16'hFC00, 16'h3C00,
                             16'h8000, 16'h3C00, 16'h0000, 16'h3C00};
    logic [15:0] vq [16] = '{16'h4200, 16'h3555, 16'hC400, 16'h7C00,
                             16'h0000, 16'h7C00, 16'h7E00, 16'h7E00,
                             16'h7E00, 16'hFC00, 16'h8000, 16'h8000,
                             16'hFC00, 16'h0000, 16'h7C00, 16'h3C00};
    logic vdz [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int   vlat [16] = '{14, 14, 14, 14, 14, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 0, 14};
    logic [15:0] rq;
    logic rdz, rdy;
    int lat;
    for (int i = 0; i < 16; i++) begin
      do_op(va[i], vb[i], rq, rdz, lat, rdy);
      checks++;
      if (rq !== vq[i] || rdz !== vdz[i]) begin
        errors++;
        $display("FAIL directed_%0d q/dz: got %h/%b expected %h/%b",
                 i, rq, rdz, vq[i], vdz[i]);
      end
      checks++;
      if (lat != vlat[i]) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d expected %0d",
                 i, lat, vlat[i]);
      end
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d in_ready: got high expected low", i);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y, rq, eq;
    logic rdz, edz, rdy;
    int lat;
    for (int i = 0; i < 150; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 3 == 0) y[14:10] = x[14:10] - 5'($urandom_range(0, 2));
      model(x, y, eq, edz);
      do_op(x, y, rq, rdz, lat, rdy);
      checks++;
      if (rq !== eq || rdz !== edz || lat > 14) begin
        errors++;
        $display("FAIL random %h/%h: got %h/%b lat %0d expected %h/%b",
                 x, y, rq, rdz, lat, eq, edz);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] rq;
    logic rdz, rdy;
    int lat;
    out_ready = 1'b0;
    do_op(16'h4600, 16'h4000, rq, rdz, lat, rdy);
    checks++;
    if (rq !== 16'h4200 || lat != 14) begin
      errors++;
      $display("FAIL bp_result: got %h lat %0d expected 4200 lat 14",
               rq, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'h3C00;
      b = 16'h4200;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || q !== 16'h4200 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v%b q%h r%b expected v1 q4200 r0",
                 i, out_valid, q, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v%b r%b expected v0 r1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rq;
    logic rdz, rdy, seen;
    int lat;
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got v%b r%b q%h expected v0 r1 q0000",
               out_valid, in_ready, q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: got out_valid high expected none");
    end
    do_op(16'hC000, 16'h3800, rq, rdz, lat, rdy);
    checks++;
    if (rq !== 16'hC400 || rdz !== 1'b0 || lat != 14) begin
      errors++;
      $display("FAIL after_reset: got %h/%b lat %0d expected c400/0 lat 14",
               rq, rdz, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
